sample_store_fifo: RTL and testbench
====================================

// Module: sample_store_fifo
// PURPOSE
//  Parametrised single-clock sample buffer between the acquisition front end and the host read-out path.
//  Two modes: OSZI stores raw ADC words; DOP stores complex {IM,RE} pairs.
//  READY2READ / READY2WRITE are hysteretic, level-driven handshake flags; level, sticky error flags and registered read data are exported.
//  Mode switch flushes the buffer.
// PARAMETERS
//  CPLX_W    32  width of RE_IN and IM_IN; storage word is 2*CPLX_W
//  OSZI_W    16  width of DIN (oscilloscope sample), OSZI_W <= 2*CPLX_W
//  DEPTH     512 entries, power of two, >= 4
//  AF_LEVEL  448 level at which READY2READ rises / READY2WRITE falls (AE_LEVEL < AF_LEVEL <= DEPTH)
//  AE_LEVEL  64  level at which READY2READ falls / READY2WRITE rises (0 <= AE_LEVEL)
// PORTS
//  CLK          in   1            single clock; all logic on posedge
//  RESET        in   1            synchronous, active-high
//  MODE         in   1            OSZI_MODE / DOP_MODE (package constants)
//  WRITE        in   1            write strobe, one entry per cycle high
//  READ         in   1            read strobe, one entry per cycle high
//  DIN          in   OSZI_W       OSZI sample
//  RE_IN,IM_IN  in   CPLX_W       DOP complex sample
//  DOUT         out  2*CPLX_W     registered read data
//  DVALID       out  1            DOUT updated this cycle
//  LEVEL        out  log2(DEPTH)+1 current entry count
//  FULL, EMPTY  out  1            LEVEL==DEPTH / LEVEL==0
//  READY2READ   out  1            hysteretic "block ready for host"
//  READY2WRITE  out  1            hysteretic "front end may write"
//  OVERFLOW     out  1            sticky: write attempted while FULL
//  UNDERFLOW    out  1            sticky: read attempted while EMPTY
// BEHAVIOUR
//  Reset values (RESET sampled high on a CLK edge): pointers=0, LEVEL=0, EMPTY=1, FULL=0, DOUT=0, DVALID=0,
//   READY2READ=0, READY2WRITE=1, OVERFLOW=0, UNDERFLOW=0, mode_q=MODE. RESET overrides every other input.
//  Write word: OSZI -> zero-extended DIN; DOP -> {IM_IN,RE_IN}.
//  Write accepted iff WRITE && (!FULL || READ); otherwise dropped and OVERFLOW set.
//  Read accepted iff READ && !EMPTY; DOUT = oldest entry on the next edge (1-cycle latency), DVALID=1 for that one cycle.
//   Otherwise DOUT holds; READ && EMPTY sets UNDERFLOW.
//  Simultaneous WRITE+READ: full -> both accepted, LEVEL unchanged. Empty -> write accepted, read refused, UNDERFLOW set (no fall-through).
//  Pointers wrap modulo DEPTH; LEVEL computed from the accepted strobes, never from the pointer difference.
//  Flag FSM (states LOW, HIGH), driven by the next-cycle LEVEL:
//   LOW  (R2R=0, R2W=1) -> HIGH when LEVEL >= AF_LEVEL
//   HIGH (R2R=1, R2W=0) -> LOW  when LEVEL <= AE_LEVEL
//   Flags update on the same edge as LEVEL. No toggling between the thresholds.
//  Mode change: on an edge where MODE != mode_q -> flush to reset state except the sticky flags; mode_q <= MODE.
//   WRITE/READ on that edge are ignored.
//  Sticky flags are cleared only by RESET.
// STRUCTURE
//  Shared package (storage_pkg): OSZI_MODE=1'b1, DOP_MODE=1'b0, flag-FSM state typedef {LOW,HIGH}.
//  One sub-module, sfifo_ram: simple dual-port RAM, DEPTH x 2*CPLX_W, registered read, EBR-inferable.
//  Pointer/level/flag/mode logic stays in this module.
// TESTING (DEPTH=16, AF_LEVEL=12, AE_LEVEL=4, CPLX_W=32, OSZI_W=16)
//  1. OSZI, write DIN=0x0001..0x000C -> R2R rises on the edge where LEVEL hits 12; R2W=0; read 8 -> DOUT 1..8 each 1 cycle after READ;
//     R2R falls when LEVEL==4.
//  2. DOP, write RE=0x11,IM=0x22 -> first read DOUT=0x00000022_00000011, DVALID pulses once.
//  3. Fill 16, then WRITE alone -> OVERFLOW=1, LEVEL=16; WRITE+READ together -> LEVEL stays 16, data order intact across wrap.
//  4. Empty, READ+WRITE same cycle -> LEVEL=1, UNDERFLOW=1, DVALID=0.
//  5. LEVEL=10, toggle MODE -> next edge LEVEL=0, EMPTY=1, R2R=0, R2W=1, sticky flags unchanged.
//  6. Assert RESET mid-burst at LEVEL=13 -> all outputs at reset values next edge, OVERFLOW/UNDERFLOW cleared.

Source files
------------

// File: rtl/sample_store_fifo_pkg.sv
// Shared constants and types for the sample store FIFO: mode encodings and
// the hysteretic handshake-flag FSM state.
package storage_pkg;

    localparam logic OSZI_MODE = 1'b1;
    localparam logic DOP_MODE  = 1'b0;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } flag_state_e;

endpackage

// File: rtl/sample_store_fifo_if.sv
// Front-end/host bus of the sample store FIFO. The master drives strobes and
// sample data; the slave (the FIFO) returns read data, level and status flags.
interface sample_store_fifo_if #(
    parameter int CPLX_W = 32,
    parameter int OSZI_W = 16,
    parameter int DEPTH  = 512
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                MODE;
    logic                WRITE;
    logic                READ;
    logic [OSZI_W-1:0]   DIN;
    logic [CPLX_W-1:0]   RE_IN;
    logic [CPLX_W-1:0]   IM_IN;
    logic [2*CPLX_W-1:0] DOUT;
    logic                DVALID;
    logic [LVL_W-1:0]    LEVEL;
    logic                FULL;
    logic                EMPTY;
    logic                READY2READ;
    logic                READY2WRITE;
    logic                OVERFLOW;
    logic                UNDERFLOW;

    modport master (
        output MODE, WRITE, READ, DIN, RE_IN, IM_IN,
        input  DOUT, DVALID, LEVEL, FULL, EMPTY,
        input  READY2READ, READY2WRITE, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  MODE, WRITE, READ, DIN, RE_IN, IM_IN,
        output DOUT, DVALID, LEVEL, FULL, EMPTY,
        output READY2READ, READY2WRITE, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/sample_store_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port, with no
// reset on the array or the read register so it maps onto block RAM.
module sfifo_ram #(
    parameter int DW    = 64,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-address write+read returns the old entry.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sample_store_fifo.sv
// Single-clock sample buffer for OSZI (raw ADC) and DOP (complex) samples with
// hysteretic READY2READ/READY2WRITE flags, sticky error flags and mode flush.
module sample_store_fifo
    import storage_pkg::*;
#(
    parameter int CPLX_W   = 32,
    parameter int OSZI_W   = 16,
    parameter int DEPTH    = 512,
    parameter int AF_LEVEL = 448,
    parameter int AE_LEVEL = 64
) (
    input logic              CLK,
    input logic              RESET,
    sample_store_fifo_if.slave bus
);
    localparam int DW    = 2 * CPLX_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             mode_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             dvalid_q, dvalid_d;
    logic [DW-1:0]    hold_q, ram_rdata, wr_word;
    logic             full, empty, flush, wr_acc, rd_acc;
    flag_state_e      state_q, state_d;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        flush   = (bus.MODE != mode_q);
        wr_acc  = !flush && bus.WRITE && (!full || bus.READ);
        rd_acc  = !flush && bus.READ && !empty;

        wr_word = '0;
        if (mode_q == OSZI_MODE) begin
            wr_word[OSZI_W-1:0] = bus.DIN;
        end else begin
            wr_word = {bus.IM_IN, bus.RE_IN};
        end

        wptr_d   = wptr_q + PTR_W'(wr_acc);
        rptr_d   = rptr_q + PTR_W'(rd_acc);
        level_d  = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
        dvalid_d = rd_acc;
        ovf_d    = ovf_q | (!flush && bus.WRITE && !wr_acc);
        udf_d    = udf_q | (!flush && bus.READ && empty);

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
    end

    // Flags follow the post-edge level so they move on the same edge as LEVEL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOW:     if (level_d >= LVL_W'(AF_LEVEL)) state_d = HIGH;
            HIGH:    if (level_d <= LVL_W'(AE_LEVEL)) state_d = LOW;
            default: state_d = LOW;
        endcase
        if (flush) begin
            state_d = LOW;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            dvalid_q <= 1'b0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            state_q  <= LOW;
            mode_q   <= bus.MODE;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            state_q  <= state_d;
            mode_q   <= bus.MODE;
            // hold_q shadows the RAM read register so DOUT can be cleared and held.
            if (flush) begin
                hold_q <= '0;
            end else if (dvalid_q) begin
                hold_q <= ram_rdata;
            end
        end
    end

    sfifo_ram #(
        .DW   (DW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (CLK),
        .we_i   (wr_acc && !RESET),
        .waddr_i(wptr_q),
        .wdata_i(wr_word),
        .re_i   (rd_acc && !RESET),
        .raddr_i(rptr_q),
        .rdata_o(ram_rdata)
    );

    assign bus.DOUT        = dvalid_q ? ram_rdata : hold_q;
    assign bus.DVALID      = dvalid_q;
    assign bus.LEVEL       = level_q;
    assign bus.FULL        = full;
    assign bus.EMPTY       = empty;
    assign bus.READY2READ  = (state_q == HIGH);
    assign bus.READY2WRITE = (state_q == LOW);
    assign bus.OVERFLOW    = ovf_q;
    assign bus.UNDERFLOW   = udf_q;
endmodule

// File: tb/tb_sample_store_fifo.sv
// Self-checking bench for sample_store_fifo: directed tables and sequences
// plus randomized traffic checked against a queue-based reference model.
module tb_sample_store_fifo;
    localparam int CPLX_W = 32;
    localparam int OSZI_W = 16;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sample_store_fifo_if #(.CPLX_W(CPLX_W), .OSZI_W(OSZI_W), .DEPTH(DEPTH)) bus ();

    sample_store_fifo #(
        .CPLX_W  (CPLX_W),
        .OSZI_W  (OSZI_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    // Reference model state
    logic [63:0] mq[$];
    logic [63:0] m_dout;
    logic        m_dvalid, m_ovf, m_udf, m_hi, m_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("level",  64'(bus.LEVEL), 64'(mq.size()));
        chk("full",   64'(bus.FULL), 64'(mq.size() == DEPTH));
        chk("empty",  64'(bus.EMPTY), 64'(mq.size() == 0));
        chk("dout",   bus.DOUT, m_dout);
        chk("dvalid", 64'(bus.DVALID), 64'(m_dvalid));
        chk("r2r",    64'(bus.READY2READ), 64'(m_hi));
        chk("r2w",    64'(bus.READY2WRITE), 64'(!m_hi));
        chk("ovf",    64'(bus.OVERFLOW), 64'(m_ovf));
        chk("udf",    64'(bus.UNDERFLOW), 64'(m_udf));
    endtask

    task automatic model_update(input logic r, input logic md, input logic wr, input logic rd,
                                input logic [15:0] din, input logic [31:0] re, input logic [31:0] im);
        int n;
        logic full_m, empty_m, wr_ok, rd_ok;
        if (r || md != m_mode) begin
            mq.delete();
            m_dout   = '0;
            m_dvalid = 1'b0;
            m_hi     = 1'b0;
            if (r) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            m_mode = md;
            return;
        end
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        rd_ok   = rd && !empty_m;
        wr_ok   = wr && (!full_m || rd);
        m_dvalid = rd_ok;
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(m_mode ? {48'd0, din} : {im, re});
        if (wr && !wr_ok) m_ovf = 1'b1;
        if (rd && empty_m) m_udf = 1'b1;
        n = mq.size();
        if (!m_hi && n >= AF) m_hi = 1'b1;
        else if (m_hi && n <= AE) m_hi = 1'b0;
    endtask

    task automatic step(input logic r, input logic md, input logic wr, input logic rd,
                        input logic [15:0] din, input logic [31:0] re, input logic [31:0] im);
        rst       = r;
        bus.MODE  = md;
        bus.WRITE = wr;
        bus.READ  = rd;
        bus.DIN   = din;
        bus.RE_IN = re;
        bus.IM_IN = im;
        model_update(r, md, wr, rd, din, re, im);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        int          exp_level;
        logic        exp_r2r;
        logic        exp_dvalid;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t tbl[20];

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{1'b1, 1'b0, 16'(i + 1), i + 1, (i + 1) >= 12, 1'b0, 64'd0};
        end
        for (int j = 0; j < 8; j++) begin
            tbl[12 + j] = '{1'b0, 1'b1, 16'd0, 11 - j, (11 - j) > 4, 1'b1, 64'(j + 1)};
        end

        m_mode = 1'b1; m_dout = '0; m_dvalid = 0; m_ovf = 0; m_udf = 0; m_hi = 0;

        // Reset state
        step(1, 1, 0, 0, 0, 0, 0);
        chk("rst_level", 64'(bus.LEVEL), 64'd0);
        chk("rst_empty", 64'(bus.EMPTY), 64'd1);
        chk("rst_r2w",   64'(bus.READY2WRITE), 64'd1);
        chk("rst_dout",  bus.DOUT, 64'd0);

        // Test 1: OSZI fill to 12, drain 8
        for (int i = 0; i < 20; i++) begin
            step(0, 1, tbl[i].wr, tbl[i].rd, tbl[i].din, 32'hDEAD, 32'hBEEF);
            chk("t1_level",  64'(bus.LEVEL), 64'(tbl[i].exp_level));
            chk("t1_r2r",    64'(bus.READY2READ), 64'(tbl[i].exp_r2r));
            chk("t1_r2w",    64'(bus.READY2WRITE), 64'(!tbl[i].exp_r2r));
            chk("t1_dvalid", 64'(bus.DVALID), 64'(tbl[i].exp_dvalid));
            chk("t1_dout",   bus.DOUT, tbl[i].exp_dout);
        end

        // Test 2: DOP word packing
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 16'hFFFF, 32'h11, 32'h22);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("t2_dout",   bus.DOUT, 64'h00000022_00000011);
        chk("t2_dvalid", 64'(bus.DVALID), 64'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_dvalid_off", 64'(bus.DVALID), 64'd0);
        chk("t2_dout_hold",  bus.DOUT, 64'h00000022_00000011);

        // Test 3: overflow and full write+read across the wrap
        step(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 1, 1, 0, 16'(k + 1), 0, 0);
        chk("t3_full",  64'(bus.FULL), 64'd1);
        step(0, 1, 1, 0, 16'h00AA, 0, 0);
        chk("t3_ovf",   64'(bus.OVERFLOW), 64'd1);
        chk("t3_level", 64'(bus.LEVEL), 64'd16);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1, 1, 16'(17 + k), 0, 0);
            chk("t3_wr_dout",  bus.DOUT, 64'(k + 1));
            chk("t3_wr_level", 64'(bus.LEVEL), 64'd16);
        end

        // Test 4: empty with simultaneous read+write
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 16'd5, 0, 0);
        chk("t4_level",  64'(bus.LEVEL), 64'd1);
        chk("t4_udf",    64'(bus.UNDERFLOW), 64'd1);
        chk("t4_dvalid", 64'(bus.DVALID), 64'd0);

        // Test 5: mode toggle flushes, sticky flags survive
        for (int k = 0; k < 9; k++) step(0, 1, 1, 0, 16'(k), 0, 0);
        chk("t5_level_pre", 64'(bus.LEVEL), 64'd10);
        step(0, 0, 1, 1, 16'h1234, 1, 2);
        chk("t5_level", 64'(bus.LEVEL), 64'd0);
        chk("t5_empty", 64'(bus.EMPTY), 64'd1);
        chk("t5_r2r",   64'(bus.READY2READ), 64'd0);
        chk("t5_r2w",   64'(bus.READY2WRITE), 64'd1);
        chk("t5_udf",   64'(bus.UNDERFLOW), 64'd1);
        chk("t5_ovf",   64'(bus.OVERFLOW), 64'd0);

        // Test 6: reset mid-burst at level 13
        for (int k = 0; k < 13; k++) step(0, 0, 1, 0, 0, 32'(k), 32'(k * 3));
        chk("t6_level_pre", 64'(bus.LEVEL), 64'd13);
        chk("t6_r2r_pre",   64'(bus.READY2READ), 64'd1);
        step(1, 0, 1, 1, 0, 7, 7);
        chk("t6_level",  64'(bus.LEVEL), 64'd0);
        chk("t6_empty",  64'(bus.EMPTY), 64'd1);
        chk("t6_full",   64'(bus.FULL), 64'd0);
        chk("t6_dout",   bus.DOUT, 64'd0);
        chk("t6_dvalid", 64'(bus.DVALID), 64'd0);
        chk("t6_r2r",    64'(bus.READY2READ), 64'd0);
        chk("t6_r2w",    64'(bus.READY2WRITE), 64'd1);
        chk("t6_ovf",    64'(bus.OVERFLOW), 64'd0);
        chk("t6_udf",    64'(bus.UNDERFLOW), 64'd0);

        // Randomized traffic with biased write/read rates per phase
        begin
            int wp[4] = '{80, 30, 60, 90};
            int rp[4] = '{30, 80, 60, 90};
            logic md = 1'b0;
            for (int p = 0; p < 4; p++) begin
                for (int c = 0; c < 500; c++) begin
                    logic r, wr, rd;
                    r  = ($urandom_range(399) == 0);
                    if ($urandom_range(199) == 0) md = ~md;
                    wr = ($urandom_range(99) < wp[p]);
                    rd = ($urandom_range(99) < rp[p]);
                    step(r, md, wr, rd, 16'($urandom), $urandom, $urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
